// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receive deserializer: comma hunt, lock, then byte delivery with strobe.
// Optional loss-of-alignment detection is compiled in with SERIAL_RX_LOSS_DETECT_EN.

module serial_paralelo_rx #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned MAX_GAP    = 16
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    // state    | meaning
    // SEARCH   | sliding-window hunt for a comma on any bit offset
    // LOCKING  | byte phase fixed, counting consecutive boundary commas
    // ALIGNED  | locked, bytes delivered at every boundary
    typedef enum logic [1:0] {SEARCH, LOCKING, ALIGNED} state_t;

    localparam logic [3:0] LOCK_LIM = 4'(LOCK_COUNT);

    state_t     state;
    state_t     state_nxt;
    // Only seven history bits are needed: the window always includes data_in.
    logic [6:0] sr;
    logic [7:0] w;
    logic [2:0] bit_cnt;
    logic [3:0] comma_run;
    logic       is_comma;
    logic       boundary;
    logic       gap_hit;

    assign w        = {sr, data_in};
    assign is_comma = (w == COMMA);
    assign boundary = (bit_cnt == 3'd7);

`ifdef SERIAL_RX_LOSS_DETECT_EN
    localparam logic [7:0] GAP_LIM = 8'(MAX_GAP);
    logic [7:0] gap_cnt;

    assign gap_hit = (state == ALIGNED) && boundary && !is_comma
                     && ((gap_cnt + 8'd1) == GAP_LIM);

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            gap_cnt <= 8'd0;
        end else if (state != ALIGNED) begin
            gap_cnt <= 8'd0;
        end else if (boundary) begin
            if (is_comma || gap_hit) begin
                gap_cnt <= 8'd0;
            end else begin
                gap_cnt <= gap_cnt + 8'd1;
            end
        end
    end
`else
    assign gap_hit = 1'b0;
`endif

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state <= SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SEARCH: begin
                if (is_comma) begin
                    state_nxt = (LOCK_LIM == 4'd1) ? ALIGNED : LOCKING;
                end
            end
            LOCKING: begin
                if (boundary) begin
                    if (!is_comma) begin
                        state_nxt = SEARCH;
                    end else if ((comma_run + 4'd1) == LOCK_LIM) begin
                        state_nxt = ALIGNED;
                    end
                end
            end
            ALIGNED: begin
                if (gap_hit) begin
                    state_nxt = SEARCH;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    always_comb begin
        active = (state == ALIGNED);
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            sr        <= 7'd0;
            bit_cnt   <= 3'd0;
            comma_run <= 4'd0;
        end else begin
            sr <= w[6:0];
            case (state)
                SEARCH: begin
                    if (is_comma) begin
                        bit_cnt   <= 3'd0;
                        comma_run <= 4'd1;
                    end
                end
                LOCKING: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (boundary) begin
                        comma_run <= is_comma ? (comma_run + 4'd1) : 4'd0;
                    end
                end
                ALIGNED: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (gap_hit) begin
                        comma_run <= 4'd0;
                    end
                end
                default: begin
                    bit_cnt   <= 3'd0;
                    comma_run <= 4'd0;
                end
            endcase
        end
    end

    // The byte that trips loss detection is still delivered; outputs drop on the following edge.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            data_out    <= 8'd0;
            valid_out   <= 1'b0;
            byte_strobe <= 1'b0;
        end else if (state == ALIGNED) begin
            byte_strobe <= boundary;
            if (boundary) begin
                data_out  <= w;
                valid_out <= !is_comma;
            end
        end else begin
            valid_out   <= 1'b0;
            byte_strobe <= 1'b0;
        end
    end

endmodule
